// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Shared UART definitions: receive state encoding, default clocking, divider.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned C_CLOCK_FREQ = 32'd16_000_000;
  localparam int unsigned C_BAUD       = 32'd9_600;

  // Clock cycles per oversample tick; integer division truncates.
  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clock_freq / (baud * oversample);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
// ============================================================================
// Module : uart_rx_deser_if
// Serial line input plus the byte valid/ack handshake and status pulses.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             rx_in;
  logic             rx_ack;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    input  rx_in,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output busy,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx_in,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  busy,
    input  frame_err,
    input  overrun
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
// ============================================================================
// Module : uart_rx_tick_gen
// Free-running divider emitting a one-cycle tick every DIV clocks.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_tick_gen #(
  parameter int unsigned DIV = 104
) (
  input  wire logic clk,
  input  wire logic rst_n,
  output logic      tick
);
  localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

`default_nettype wire

// File: rtl/uart_rx_deser.sv
// ============================================================================
// Module : uart_rx_deser
// Oversampling UART receiver, LSB-first, valid/ack byte handshake.
// Optional parity state enabled by defining UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = C_CLOCK_FREQ,
  parameter int unsigned BAUD       = C_BAUD,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  uart_rx_deser_if.master rx_if
);
  localparam int unsigned DIV    = calc_div(CLOCK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(WIDTH + 1);
  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic tick;

  uart_rx_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  rx_state_e        state_q, state_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             complete;
  logic             err_now;
  logic             sample_now;

  always_comb begin
    sync1_d     = rx_if.rx_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    err_d       = err_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_if.rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;
    err_now     = err_q;
    sample_now  = 1'b0;

    // Sample counter shared by all bit states; START uses the half-bit point.
    if (tick && state_q != IDLE) begin
      if (samp_cnt_q == ((state_q == START) ? HALF_LAST : FULL_LAST)) begin
        samp_cnt_d = '0;
        sample_now = 1'b1;
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        // Requiring prev high keeps a held-low break from retriggering.
        if (prev_q && !sync2_q) begin
          state_d    = START;
          samp_cnt_d = '0;
        end
      end
      START: begin
        if (sample_now) begin
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
            err_d     = 1'b0;
          end
        end
      end
      DATA: begin
        if (sample_now) begin
          shift_d = {sync2_q, shift_q[WIDTH-1:1]};
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_now) begin
          err_d   = (sync2_q != ((^shift_q) ^ PARITY_ODD));
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample_now) begin
          err_now = err_q | ~sync2_q;
          err_d   = err_now;
          if (bit_idx_q == STOP_LAST) begin
            state_d  = IDLE;
            complete = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A coinciding ack frees the holding register for the new byte.
    if (complete) begin
      if (err_now) begin
        frame_err_d = 1'b1;
      end else if (!rx_valid_q || rx_if.rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.busy      = (state_q != IDLE);
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
endmodule

`default_nettype wire
